// File: rtl/trap_sequencer.sv
// M-mode trap/return sequencer: kills the trapping MEM-stage instruction, streams
// mepc/mcause/mstatus through the CSR write port, then redirects fetch.
module trap_sequencer #(
   parameter int XLEN       = 32,
   parameter int CSR_ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inst_valid,
   input  logic [XLEN-1:0]       inst_pc,
   input  logic [1:0]            exc_status,
   input  logic                  invalid_instruction,
   input  logic                  meip,
   input  logic                  mtip,
   input  logic [XLEN-1:0]       mstatus_in,
   input  logic [XLEN-1:0]       mie_in,
   input  logic [XLEN-1:0]       mtvec_in,
   input  logic [XLEN-1:0]       mepc_in,
   output logic                  trap_kill,
   output logic                  busy,
   output logic                  csr_we,
   output logic [CSR_ADDR_W-1:0] csr_waddr,
   output logic [XLEN-1:0]       csr_wdata,
   output logic                  redirect_valid,
   output logic [XLEN-1:0]       redirect_pc
);

   localparam logic [CSR_ADDR_W-1:0] ADDR_MSTATUS = CSR_ADDR_W'(12'h300);
   localparam logic [CSR_ADDR_W-1:0] ADDR_MEPC    = CSR_ADDR_W'(12'h341);
   localparam logic [CSR_ADDR_W-1:0] ADDR_MCAUSE  = CSR_ADDR_W'(12'h342);

   localparam logic [XLEN-1:0] CAUSE_MEI     = {1'b1, (XLEN-1)'(11)};
   localparam logic [XLEN-1:0] CAUSE_MTI     = {1'b1, (XLEN-1)'(7)};
   localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
   localparam logic [XLEN-1:0] CAUSE_BREAK   = XLEN'(3);
   localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);

   typedef enum logic [2:0] {
      IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS, REDIR
   } state_t;

   state_t                  state_q, state_d;
   logic                    mret_q, mret_d;
   logic [XLEN-1:0]         pc_q, pc_d;
   logic [XLEN-1:0]         cause_q, cause_d;
   logic [XLEN-1:0]         mstatus_q, mstatus_d;
   logic [XLEN-1:0]         mtvec_q, mtvec_d;
   logic [XLEN-1:0]         mepc_q, mepc_d;
   logic                    csr_we_q, csr_we_d;
   logic [CSR_ADDR_W-1:0]   csr_waddr_q, csr_waddr_d;
   logic [XLEN-1:0]         csr_wdata_q, csr_wdata_d;
   logic                    redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]         redirect_pc_q, redirect_pc_d;

   logic                    irq_ext, irq_tim, trig, trig_mret;
   logic [XLEN-1:0]         trig_cause, base, ms_trap, ms_ret;
   logic                    unused_ok;

   assign unused_ok = ^{mie_in, mstatus_in};

   always_comb begin
      irq_ext    = meip & mie_in[11] & mstatus_in[3];
      irq_tim    = mtip & mie_in[7] & mstatus_in[3];
      trig_mret  = 1'b0;
      trig_cause = '0;
      if (irq_ext)                  trig_cause = CAUSE_MEI;
      else if (irq_tim)             trig_cause = CAUSE_MTI;
      else if (invalid_instruction) trig_cause = CAUSE_ILLEGAL;
      else if (exc_status == 2'b10) trig_cause = CAUSE_BREAK;
      else if (exc_status == 2'b01) trig_cause = CAUSE_ECALL;
      else if (exc_status == 2'b11) trig_mret  = 1'b1;
      trig = (state_q == IDLE) & inst_valid &
             (irq_ext | irq_tim | invalid_instruction | (exc_status != 2'b00));
   end

   assign trap_kill = trig;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      mret_d    = mret_q;
      pc_d      = pc_q;
      cause_d   = cause_q;
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      case (state_q)
         IDLE: if (trig) begin
            state_d   = trig_mret ? R_MSTATUS : T_MEPC;
            mret_d    = trig_mret;
            pc_d      = inst_pc;
            cause_d   = trig_cause;
            mstatus_d = mstatus_in;
            mtvec_d   = mtvec_in;
            mepc_d    = mepc_in;
         end
         T_MEPC:    state_d = T_MCAUSE;
         T_MCAUSE:  state_d = T_MSTATUS;
         T_MSTATUS: state_d = REDIR;
         R_MSTATUS: state_d = REDIR;
         REDIR:     state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the next state and the
   // next capture values to be valid in the cycle the state is entered.
   always_comb begin
      ms_trap          = mstatus_d;
      ms_trap[7]       = mstatus_d[3];
      ms_trap[3]       = 1'b0;
      ms_trap[12:11]   = 2'b11;
      ms_ret           = mstatus_d;
      ms_ret[3]        = mstatus_d[7];
      ms_ret[7]        = 1'b1;
      ms_ret[12:11]    = 2'b11;
      base             = mtvec_d & ~XLEN'(3);
      csr_we_d         = 1'b0;
      csr_waddr_d      = '0;
      csr_wdata_d      = '0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
      case (state_d)
         T_MEPC: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = ADDR_MEPC;
            csr_wdata_d = pc_d & ~XLEN'(3);
         end
         T_MCAUSE: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = ADDR_MCAUSE;
            csr_wdata_d = cause_d;
         end
         T_MSTATUS: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = ADDR_MSTATUS;
            csr_wdata_d = ms_trap;
         end
         R_MSTATUS: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = ADDR_MSTATUS;
            csr_wdata_d = ms_ret;
         end
         REDIR: begin
            redirect_valid_d = 1'b1;
            if (mret_d)
               redirect_pc_d = mepc_d & ~XLEN'(3);
            else if (mtvec_d[1:0] == 2'b01 && cause_d[XLEN-1])
               redirect_pc_d = base + {cause_d[XLEN-3:0], 2'b00};
            else
               redirect_pc_d = base;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         mret_q           <= 1'b0;
         pc_q             <= '0;
         cause_q          <= '0;
         mstatus_q        <= '0;
         mtvec_q          <= '0;
         mepc_q           <= '0;
         csr_we_q         <= 1'b0;
         csr_waddr_q      <= '0;
         csr_wdata_q      <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         mret_q           <= mret_d;
         pc_q             <= pc_d;
         cause_q          <= cause_d;
         mstatus_q        <= mstatus_d;
         mtvec_q          <= mtvec_d;
         mepc_q           <= mepc_d;
         csr_we_q         <= csr_we_d;
         csr_waddr_q      <= csr_waddr_d;
         csr_wdata_q      <= csr_wdata_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign csr_we         = csr_we_q;
   assign csr_waddr      = csr_waddr_q;
   assign csr_wdata      = csr_wdata_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: per-cycle output vectors against hand-computed values.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inst_valid, invalid_instruction, meip, mtip;
   logic [31:0] inst_pc, mstatus_in, mie_in, mtvec_in, mepc_in;
   logic [1:0]  exc_status;
   logic        trap_kill, busy, csr_we, redirect_valid;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata, redirect_pc;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(32), .CSR_ADDR_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_pc(inst_pc),
      .exc_status(exc_status), .invalid_instruction(invalid_instruction),
      .meip(meip), .mtip(mtip), .mstatus_in(mstatus_in), .mie_in(mie_in),
      .mtvec_in(mtvec_in), .mepc_in(mepc_in), .trap_kill(trap_kill), .busy(busy),
      .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   // {trap_kill, busy, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc}
   function automatic logic [79:0] pk(input logic tk, input logic b, input logic we,
                                      input logic [11:0] a, input logic [31:0] d,
                                      input logic rv, input logic [31:0] rpc);
      return {tk, b, we, a, d, rv, rpc};
   endfunction

   function automatic logic [79:0] obs();
      return {trap_kill, busy, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc};
   endfunction

   task automatic clear_inputs();
      inst_valid = 0; inst_pc = 0; exc_status = 0; invalid_instruction = 0;
      meip = 0; mtip = 0; mstatus_in = 0; mie_in = 0; mtvec_in = 0; mepc_in = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      tot_cnt++;
      if (obs() !== 80'd0) $display("FAIL reset_state got=%h exp=%h", obs(), 80'd0);
      else pass_cnt++;
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_ecall();
      logic [79:0] ex [5];
      ex[0] = pk(0, 1, 1, 12'h341, 32'h100, 0, 0);
      ex[1] = pk(0, 1, 1, 12'h342, 32'd11, 0, 0);
      ex[2] = pk(0, 1, 1, 12'h300, 32'h1880, 0, 0);
      ex[3] = pk(0, 1, 0, 0, 0, 1, 32'h200);
      ex[4] = 80'd0;
      inst_valid = 1; inst_pc = 32'h100; exc_status = 2'b01;
      mtvec_in = 32'h200; mstatus_in = 32'h8;
      #1;
      tot_cnt++;
      if (trap_kill !== 1'b1) $display("FAIL ecall_kill got=%b exp=1", trap_kill);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         tot_cnt++;
         if (obs() !== ex[i]) $display("FAIL ecall_cyc%0d got=%h exp=%h", i, obs(), ex[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_mret();
      logic [79:0] ex [3];
      ex[0] = pk(0, 1, 1, 12'h300, 32'h1888, 0, 0);
      ex[1] = pk(0, 1, 0, 0, 0, 1, 32'h104);
      ex[2] = 80'd0;
      inst_valid = 1; inst_pc = 32'h300; exc_status = 2'b11;
      mepc_in = 32'h104; mstatus_in = 32'h1880; mtvec_in = 32'h200;
      #1;
      tot_cnt++;
      if (trap_kill !== 1'b1) $display("FAIL mret_kill got=%b exp=1", trap_kill);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         tot_cnt++;
         if (obs() !== ex[i]) $display("FAIL mret_cyc%0d got=%h exp=%h", i, obs(), ex[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_vectored_timer();
      logic [79:0] ex [5];
      ex[0] = pk(0, 1, 1, 12'h341, 32'h40, 0, 0);
      ex[1] = pk(0, 1, 1, 12'h342, 32'h80000007, 0, 0);
      ex[2] = pk(0, 1, 1, 12'h300, 32'h1880, 0, 0);
      ex[3] = pk(0, 1, 0, 0, 0, 1, 32'h21C);
      ex[4] = 80'd0;
      inst_valid = 1; inst_pc = 32'h40; mtip = 1; mie_in = 32'h80;
      mstatus_in = 32'h8; mtvec_in = 32'h201;
      @(negedge clk);
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         tot_cnt++;
         if (obs() !== ex[i]) $display("FAIL vtimer_cyc%0d got=%h exp=%h", i, obs(), ex[i]);
         else pass_cnt++;
         @(negedge clk);
      end
      // Same stimulus with global MIE clear: must not trigger.
      inst_valid = 1; inst_pc = 32'h40; mtip = 1; mie_in = 32'h80;
      mstatus_in = 32'h0; mtvec_in = 32'h201;
      #1;
      tot_cnt++;
      if (trap_kill !== 1'b0) $display("FAIL vtimer_masked_kill got=%b exp=0", trap_kill);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      tot_cnt++;
      if (obs() !== 80'd0) $display("FAIL vtimer_masked_idle got=%h exp=%h", obs(), 80'd0);
      else pass_cnt++;
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_simultaneous();
      logic [79:0] ex [5];
      ex[0] = pk(0, 1, 1, 12'h341, 32'h300, 0, 0);
      ex[1] = pk(0, 1, 1, 12'h342, 32'h8000000B, 0, 0);
      ex[2] = pk(0, 1, 1, 12'h300, 32'h1880, 0, 0);
      ex[3] = pk(0, 1, 0, 0, 0, 1, 32'h100);
      ex[4] = 80'd0;
      inst_valid = 1; inst_pc = 32'h300; exc_status = 2'b01; meip = 1; mtip = 1;
      mie_in = 32'h880; mstatus_in = 32'h8; mtvec_in = 32'h100;
      @(negedge clk);
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         tot_cnt++;
         if (obs() !== ex[i]) $display("FAIL irq_prio_cyc%0d got=%h exp=%h", i, obs(), ex[i]);
         else pass_cnt++;
         @(negedge clk);
      end
      // Illegal with ecall encoding; vectored mtvec but exception -> base; pc low bits cleared.
      ex[0] = pk(0, 1, 1, 12'h341, 32'h50, 0, 0);
      ex[1] = pk(0, 1, 1, 12'h342, 32'd2, 0, 0);
      ex[2] = pk(0, 1, 1, 12'h300, 32'h1800, 0, 0);
      ex[3] = pk(0, 1, 0, 0, 0, 1, 32'h200);
      inst_valid = 1; inst_pc = 32'h52; exc_status = 2'b01; invalid_instruction = 1;
      mstatus_in = 32'h0; mtvec_in = 32'h201;
      @(negedge clk);
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         tot_cnt++;
         if (obs() !== ex[i]) $display("FAIL illegal_cyc%0d got=%h exp=%h", i, obs(), ex[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_blocked();
      logic [79:0] ex [6];
      ex[0] = pk(0, 1, 1, 12'h341, 32'h80, 0, 0);
      ex[1] = pk(0, 1, 1, 12'h342, 32'd3, 0, 0);
      ex[2] = pk(0, 1, 1, 12'h300, 32'h1800, 0, 0);
      ex[3] = pk(0, 1, 0, 0, 0, 1, 32'h40);
      ex[4] = 80'd0;
      ex[5] = 80'd0;
      // ebreak with no valid instruction
      exc_status = 2'b10; inst_pc = 32'h80; mtvec_in = 32'h40;
      #1;
      tot_cnt++;
      if (trap_kill !== 1'b0) $display("FAIL novalid_kill got=%b exp=0", trap_kill);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      tot_cnt++;
      if (obs() !== 80'd0) $display("FAIL novalid_idle got=%h exp=%h", obs(), 80'd0);
      else pass_cnt++;
      // ebreak held valid while busy must not retrigger
      inst_valid = 1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         if (i == 3) clear_inputs();
         tot_cnt++;
         if (obs() !== ex[i]) $display("FAIL busy_block_cyc%0d got=%h exp=%h", i, obs(), ex[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      inst_valid = 1; inst_pc = 32'h100; exc_status = 2'b01;
      mtvec_in = 32'h200; mstatus_in = 32'h8;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      tot_cnt++;
      if (obs() !== pk(0, 1, 1, 12'h342, 32'd11, 0, 0))
         $display("FAIL rstmid_mcause got=%h exp=%h", obs(), pk(0, 1, 1, 12'h342, 32'd11, 0, 0));
      else pass_cnt++;
      #2 rst_n = 0;
      #1;
      tot_cnt++;
      if (obs() !== 80'd0) $display("FAIL rstmid_async got=%h exp=%h", obs(), 80'd0);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tot_cnt++;
         if (obs() !== 80'd0) $display("FAIL rstmid_after%0d got=%h exp=%h", i, obs(), 80'd0);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_mret();
      test_vectored_timer();
      test_simultaneous();
      test_blocked();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle trap/return controller for the pipelined RV32I core with M-mode exceptions and interrupts.
- Sits beside the MEM stage. Consumes the decoder's exception classification (`exc_status`, `invalid_instruction`, carried down the pipe) and the interrupt pending lines.
- Kills the trapping instruction, then sequences the trap CSR writes (mepc, mcause, mstatus) through the CSR file's single write port while holding the pipeline.
- Finally redirects fetch to mtvec or mepc.

Parameters:
- XLEN, 32, datapath / CSR data width
- CSR_ADDR_W, 12, CSR address width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  MEM-stage slot holds a real (non-bubble) instruction
- inst_pc  in  XLEN  PC of the MEM-stage instruction
- exc_status  in  2  00 idle, 01 ecall, 10 ebreak, 11 mret
- invalid_instruction  in  1  illegal-instruction flag from the decoder
- meip  in  1  external interrupt pending (level)
- mtip  in  1  timer interrupt pending (level)
- mstatus_in  in  XLEN  current mstatus
- mie_in  in  XLEN  current mie
- mtvec_in  in  XLEN  current mtvec
- mepc_in  in  XLEN  current mepc
- trap_kill  out  1  combinational: suppress writeback/memory side effects of the MEM-stage instruction this cycle
- busy  out  1  sequencer active; the pipeline must stall and flush IF/ID/EX
- csr_we  out  1  trap CSR write strobe (has priority over instruction CSR writes)
- csr_waddr  out  CSR_ADDR_W  CSR address to write
- csr_wdata  out  XLEN  CSR write data
- redirect_valid  out  1  one-cycle strobe: load PC with redirect_pc
- redirect_pc  out  XLEN  new fetch address

Behaviour:
- **Reset:** state IDLE; all outputs 0; capture registers 0. Reset asserted mid-sequence aborts immediately to IDLE with no further CSR writes.
- **Interrupt enable:** `irq_ext = meip & mie_in[11] & mstatus_in[3]`; `irq_tim = mtip & mie_in[7] & mstatus_in[3]`.
- **Triggers:** evaluated only in IDLE and only when `inst_valid = 1`. Priority, highest first:
  - `irq_ext` (cause 0x8000000B)
  - `irq_tim` (cause 0x80000007)
  - `invalid_instruction` (cause 2)
  - ebreak (cause 3)
  - ecall (cause 11)
  - mret
- **On trigger in IDLE:**
  - `trap_kill = 1` combinationally in the same cycle.
  - At the clock edge, capture `inst_pc`, the cause, `mstatus_in`, `mtvec_in` and `mepc_in`.
  - The interrupted or trapping instruction does not retire; mepc receives its own PC.
- **State machine:** IDLE -> T_MEPC -> T_MCAUSE -> T_MSTATUS -> REDIR -> IDLE for traps; IDLE -> R_MSTATUS -> REDIR -> IDLE for mret. One cycle per state, unconditional advance.
- **T_MEPC:** `csr_we = 1`, addr 0x341, data = captured pc with bits [1:0] cleared.
- **T_MCAUSE:** `csr_we = 1`, addr 0x342, data = cause.
- **T_MSTATUS:** `csr_we = 1`, addr 0x300, data = captured mstatus with MPIE[7] = old MIE[3], MIE[3] = 0, MPP[12:11] = 11; all other bits are unchanged.
- **R_MSTATUS:** `csr_we = 1`, addr 0x300, data = captured mstatus with MIE[3] = old MPIE[7], MPIE[7] = 1, MPP = 11.
- **REDIR:** `redirect_valid = 1`; `csr_we = 0`.
  - mret: target = captured mepc with bits [1:0] cleared.
  - Trap with mtvec[1:0] = 01 and an interrupt cause: target = base + 4 × cause[30:0], where base = mtvec & ~3.
  - Otherwise: target = base.
- **Busy:** `busy = 1` in every non-IDLE state. Trap latency from trigger edge to redirect strobe is 4 cycles; mret latency is 2 cycles.
- **Inputs ignored:** all trigger inputs are ignored while busy. Interrupt lines still pending after the return are re-evaluated in IDLE under the new MIE.
- **Idle outputs:** `csr_we`, `csr_waddr`, `csr_wdata`, `redirect_valid` and `redirect_pc` are registered and read 0 in IDLE.
- **Invalid encoding:** `invalid_instruction = 1` with a non-idle `exc_status` is treated as illegal (cause 2).

Test Plan:
1. **ecall:** ecall at pc 0x00000100 with mtvec = 0x00000200 and mstatus = 0x00000008 -> `trap_kill` in the trigger cycle, then writes (0x341, 0x100), (0x342, 11) and (0x300, 0x00001880). Next cycle: `redirect_valid` with pc 0x200; `busy` high for exactly 4 cycles.
2. **mret:** mret with mepc = 0x00000104 and mstatus = 0x00001880 -> one write (0x300, 0x00001888), then a redirect to 0x104; 2 busy cycles.
3. **Vectored timer interrupt:** mtip = 1, mie = 0x80, MIE = 1, mtvec = 0x00000201, inst_pc = 0x40 -> mcause 0x80000007, mepc 0x40, redirect 0x21C. The same stimulus with MIE = 0 -> no trigger, `busy` stays 0.
4. **Simultaneous events:** meip and mtip both enabled together with an ecall -> mcause 0x8000000B. `invalid_instruction` with `exc_status` = 01 -> mcause 2.
5. **Blocked triggers:** an ebreak presented while busy, or with `inst_valid = 0` -> ignored, no additional CSR writes.
6. **Reset mid-sequence:** `rst_n` pulsed low during T_MCAUSE -> all outputs drop to 0 asynchronously; after release, IDLE with no mstatus write and no redirect.
